// File: rtl/systema_ram_dp_if.sv
// Avalon-MM slave port bundle for systema_ram_dp; one instance per RAM port.
// The master modport is the interconnect side, the slave modport is the RAM side.
interface systema_ram_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    chipselect;
    logic                    write;
    logic                    read;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output address, byteenable, chipselect, write, read, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, chipselect, write, read, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/systema_ram_dp.sv
// Dual-port Avalon-MM on-chip RAM with byte lanes, 1- or 2-cycle read pipeline and clock-enable freeze.
// Optional macro SYSTEMA_RAM_DP_COLLISION_EN adds sticky same-address collision flag and counter.
module systema_ram_dp #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 10,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "systema_RAM.hex"
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clken,
    input  logic            reset_req,
    systema_ram_dp_if.slave s1,
    systema_ram_dp_if.slave s2
`ifdef SYSTEMA_RAM_DP_COLLISION_EN
    ,
    output logic            collision,
    output logic [15:0]     collision_count
`endif
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  en;
    logic [ADDR_WIDTH-1:0] addr   [2];
    logic [LANES-1:0]      be     [2];
    logic [DATA_WIDTH-1:0] wdata  [2];
    logic [1:0]            wr_acc;
    logic [1:0]            rd_acc;

    logic [DATA_WIDTH-1:0] st1_data [2];
    logic [1:0]            st1_vld;
    logic [DATA_WIDTH-1:0] out_data [2];
    logic [1:0]            out_vld;

    assign en = clken & ~reset_req;

    assign addr[0]  = s1.address;
    assign addr[1]  = s2.address;
    assign be[0]    = s1.byteenable;
    assign be[1]    = s2.byteenable;
    assign wdata[0] = s1.writedata;
    assign wdata[1] = s2.writedata;

    assign wr_acc[0] = s1.chipselect & s1.write & en;
    assign wr_acc[1] = s2.chipselect & s2.write & en;
    assign rd_acc[0] = s1.chipselect & s1.read & ~s1.write & en;
    assign rd_acc[1] = s2.chipselect & s2.read & ~s2.write & en;

    // Port 2 lanes are applied first so port 1 overrides them on a same-address dual write.
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            if (wr_acc[p]) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[p][i]) begin
                        mem[addr[p]][8*i +: 8] <= wdata[p][8*i +: 8];
                    end
                end
            end
        end
    end

    // Reads sample the array before this edge's writes land, giving old data on cross-port hits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st1_vld <= '0;
            for (int p = 0; p < 2; p++) begin
                st1_data[p] <= '0;
            end
        end else if (en) begin
            st1_vld <= rd_acc;
            for (int p = 0; p < 2; p++) begin
                if (rd_acc[p]) begin
                    st1_data[p] <= mem[addr[p]];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] st2_data [2];
            logic [1:0]            st2_vld;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    st2_vld <= '0;
                    for (int p = 0; p < 2; p++) begin
                        st2_data[p] <= '0;
                    end
                end else if (en) begin
                    st2_vld <= st1_vld;
                    for (int p = 0; p < 2; p++) begin
                        st2_data[p] <= st1_data[p];
                    end
                end
            end

            assign out_data[0] = st2_data[0];
            assign out_data[1] = st2_data[1];
            assign out_vld     = st2_vld;
        end else begin : g_lat1
            assign out_data[0] = st1_data[0];
            assign out_data[1] = st1_data[1];
            assign out_vld     = st1_vld;
        end
    endgenerate

    assign s1.readdata      = out_data[0];
    assign s1.readdatavalid = out_vld[0];
    assign s2.readdata      = out_data[1];
    assign s2.readdatavalid = out_vld[1];

`ifdef SYSTEMA_RAM_DP_COLLISION_EN
    logic coll_hit;

    // A hit needs both ports active on one address with at least one of them writing.
    assign coll_hit = (addr[0] == addr[1]) &&
                      (wr_acc[0] | rd_acc[0]) && (wr_acc[1] | rd_acc[1]) &&
                      (wr_acc[0] | wr_acc[1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision       <= 1'b0;
            collision_count <= 16'd0;
        end else if (coll_hit) begin
            collision <= 1'b1;
            if (collision_count != 16'hFFFF) begin
                collision_count <= collision_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systema_ram_dp.sv
// Scoreboard bench for systema_ram_dp: latency-1 and latency-2 instances driven with identical stimulus.
// Expected read data is computed from a reference memory at accept time and popped on readdatavalid.
module tb_systema_ram_dp;

    localparam int DW = 32;
    localparam int AW = 10;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic clken;
    logic reset_req;

    logic          t_cs   [2];
    logic          t_wr   [2];
    logic          t_rd   [2];
    logic [AW-1:0] t_addr [2];
    logic [3:0]    t_be   [2];
    logic [DW-1:0] t_wd   [2];

    systema_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) l1_s1 ();
    systema_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) l1_s2 ();
    systema_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) l2_s1 ();
    systema_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) l2_s2 ();

    assign l1_s1.chipselect = t_cs[0];   assign l2_s1.chipselect = t_cs[0];
    assign l1_s1.write      = t_wr[0];   assign l2_s1.write      = t_wr[0];
    assign l1_s1.read       = t_rd[0];   assign l2_s1.read       = t_rd[0];
    assign l1_s1.address    = t_addr[0]; assign l2_s1.address    = t_addr[0];
    assign l1_s1.byteenable = t_be[0];   assign l2_s1.byteenable = t_be[0];
    assign l1_s1.writedata  = t_wd[0];   assign l2_s1.writedata  = t_wd[0];
    assign l1_s2.chipselect = t_cs[1];   assign l2_s2.chipselect = t_cs[1];
    assign l1_s2.write      = t_wr[1];   assign l2_s2.write      = t_wr[1];
    assign l1_s2.read       = t_rd[1];   assign l2_s2.read       = t_rd[1];
    assign l1_s2.address    = t_addr[1]; assign l2_s2.address    = t_addr[1];
    assign l1_s2.byteenable = t_be[1];   assign l2_s2.byteenable = t_be[1];
    assign l1_s2.writedata  = t_wd[1];   assign l2_s2.writedata  = t_wd[1];

`ifdef SYSTEMA_RAM_DP_COLLISION_EN
    logic        coll_l1, coll_l2;
    logic [15:0] ccnt_l1, ccnt_l2;
`endif

    systema_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut_l1 (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .reset_req (reset_req),
        .s1        (l1_s1),
        .s2        (l1_s2)
`ifdef SYSTEMA_RAM_DP_COLLISION_EN
        ,
        .collision       (coll_l1),
        .collision_count (ccnt_l1)
`endif
    );

    systema_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_dut_l2 (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .reset_req (reset_req),
        .s1        (l2_s1),
        .s2        (l2_s2)
`ifdef SYSTEMA_RAM_DP_COLLISION_EN
        ,
        .collision       (coll_l2),
        .collision_count (ccnt_l2)
`endif
    );

    always #5 clk = ~clk;

    // Index map: 0 = L1 s1, 1 = L1 s2, 2 = L2 s1, 3 = L2 s2
    logic        obs_vld  [4];
    logic [31:0] obs_data [4];
    assign obs_vld[0] = l1_s1.readdatavalid; assign obs_data[0] = l1_s1.readdata;
    assign obs_vld[1] = l1_s2.readdatavalid; assign obs_data[1] = l1_s2.readdata;
    assign obs_vld[2] = l2_s1.readdatavalid; assign obs_data[2] = l2_s1.readdata;
    assign obs_vld[3] = l2_s2.readdatavalid; assign obs_data[3] = l2_s2.readdata;

    logic [31:0] model_mem [int];
    exp_t        exp_q [4][$];
    int          en_count  = 0;
    bit          last_en   = 1'b0;
    int          coll_cnt  = 0;
    int          compared  = 0;
    int          mismatched = 0;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 32'h0;
    endfunction

    task automatic idle_port(input int p);
        t_cs[p] = 1'b0; t_wr[p] = 1'b0; t_rd[p] = 1'b0;
        t_addr[p] = '0; t_be[p] = '0; t_wd[p] = '0;
    endtask

    task automatic idle_all();
        idle_port(0);
        idle_port(1);
    endtask

    task automatic set_write(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        t_cs[p] = 1'b1; t_wr[p] = 1'b1; t_rd[p] = 1'b0;
        t_addr[p] = a; t_be[p] = b; t_wd[p] = d;
    endtask

    task automatic set_read(input int p, input logic [AW-1:0] a);
        t_cs[p] = 1'b1; t_wr[p] = 1'b0; t_rd[p] = 1'b1;
        t_addr[p] = a; t_be[p] = '0; t_wd[p] = '0;
    endtask

    // One clock edge: reference model consumes the inputs that were presented during the cycle.
    task automatic apply_stimulus();
        bit          en_c;
        bit          act  [2];
        bit          wra  [2];
        logic [31:0] w;
        en_c = clken && !reset_req;
        @(posedge clk);
        last_en = en_c && !reset;
        if (last_en) begin
            en_count++;
            for (int p = 0; p < 2; p++) begin
                wra[p] = t_cs[p] && t_wr[p];
                act[p] = t_cs[p] && (t_wr[p] || t_rd[p]);
                if (t_cs[p] && t_rd[p] && !t_wr[p]) begin
                    exp_q[p].push_back('{mem_rd(t_addr[p]), en_count});
                    exp_q[p+2].push_back('{mem_rd(t_addr[p]), en_count + 1});
                end
            end
            if (t_addr[0] == t_addr[1] && act[0] && act[1] && (wra[0] || wra[1])) begin
                coll_cnt++;
            end
            for (int p = 1; p >= 0; p--) begin
                if (wra[p]) begin
                    w = mem_rd(t_addr[p]);
                    for (int l = 0; l < 4; l++) begin
                        if (t_be[p][l]) w[8*l +: 8] = t_wd[p][8*l +: 8];
                    end
                    model_mem[int'(t_addr[p])] = w;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("rst_data_%0d", i), obs_data[i], 32'h0);
            check_output($sformatf("rst_valid_%0d", i), 32'(obs_vld[i]), 32'h0);
            exp_q[i].delete();
        end
        coll_cnt = 0;
    endtask

`ifdef SYSTEMA_RAM_DP_COLLISION_EN
    task automatic check_collision(input string tag);
        check_output({tag, "_flag_l1"}, 32'(coll_l1), 32'(coll_cnt > 0));
        check_output({tag, "_flag_l2"}, 32'(coll_l2), 32'(coll_cnt > 0));
        check_output({tag, "_count_l1"}, 32'(ccnt_l1), 32'(coll_cnt));
        check_output({tag, "_count_l2"}, 32'(ccnt_l2), 32'(coll_cnt));
    endtask
`endif

    // Valid is only a new pulse after an enabled edge; on frozen edges it merely holds.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && last_en) begin
            for (int i = 0; i < 4; i++) begin
                if (obs_vld[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check_output($sformatf("spurious_valid_%0d", i), 32'h1, 32'h0);
                    end else begin
                        e = exp_q[i].pop_front();
                        check_output($sformatf("rdata_%0d", i), obs_data[i], e.data);
                        check_output($sformatf("latency_%0d", i), 32'(en_count), 32'(e.due));
                    end
                end else if (exp_q[i].size() > 0 && exp_q[i][0].due <= en_count) begin
                    e = exp_q[i].pop_front();
                    check_output($sformatf("missing_valid_%0d", i), 32'h0, 32'h1);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
        idle_all();
        repeat (2) apply_stimulus();
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("init_data_%0d", i), obs_data[i], 32'h0);
            check_output($sformatf("init_valid_%0d", i), 32'(obs_vld[i]), 32'h0);
        end
        reset = 1'b0;

        set_write(0, 10'h020, 32'h0000_0000, 4'hF); set_write(1, 10'h010, 32'h1122_3344, 4'hF); apply_stimulus();
        set_write(0, 10'h001, 32'hA1A1_0001, 4'hF); set_write(1, 10'h002, 32'hB2B2_0002, 4'hF); apply_stimulus();
        set_write(0, 10'h003, 32'hC3C3_0003, 4'hF); idle_port(1); apply_stimulus();
        for (int k = 0; k < 8; k++) begin
            set_write(0, 10'(10'h040 + k), $urandom, 4'hF);
            apply_stimulus();
        end
        idle_all(); apply_stimulus();

        set_write(0, 10'h005, 32'hDEAD_BEEF, 4'hF); apply_stimulus();
        set_read(0, 10'h005); apply_stimulus();
        idle_all(); repeat (3) apply_stimulus();

        set_write(1, 10'h010, 32'hAABB_CCDD, 4'b0101); apply_stimulus();
        idle_port(1); set_read(0, 10'h010); apply_stimulus();
        idle_all(); repeat (3) apply_stimulus();

        set_write(0, 10'h020, 32'h1234_5678, 4'hF); set_read(1, 10'h020); apply_stimulus();
        idle_port(0); set_read(1, 10'h020); apply_stimulus();
        idle_all(); repeat (3) apply_stimulus();

        set_write(0, 10'h3FF, 32'hFFFF_0000, 4'b1100); set_write(1, 10'h3FF, 32'h0000_FFFF, 4'b1111); apply_stimulus();
        set_read(0, 10'h3FF); set_read(1, 10'h3FF); apply_stimulus();
        idle_all(); repeat (3) apply_stimulus();
`ifdef SYSTEMA_RAM_DP_COLLISION_EN
        check_collision("coll_dual");
`endif

        set_read(0, 10'h001); set_read(1, 10'h002); apply_stimulus();
        set_read(0, 10'h002); idle_port(1); apply_stimulus();
        clken = 1'b0;
        set_read(0, 10'h003); set_write(1, 10'h001, 32'hBAD0_BAD0, 4'hF);
        repeat (2) apply_stimulus();
        clken = 1'b1;
        set_read(0, 10'h003); idle_port(1); apply_stimulus();
        idle_all(); repeat (4) apply_stimulus();
        set_read(1, 10'h001); apply_stimulus();
        idle_all(); repeat (3) apply_stimulus();

        reset_req = 1'b1;
        set_write(0, 10'h005, 32'h0BAD_F00D, 4'hF); set_read(1, 10'h005); apply_stimulus();
        reset_req = 1'b0;
        idle_all(); apply_stimulus();
        set_read(1, 10'h005); apply_stimulus();
        idle_all(); repeat (3) apply_stimulus();

        set_read(0, 10'h005); set_read(1, 10'h010); apply_stimulus();
        idle_all();
        do_reset();
        repeat (2) apply_stimulus();
        reset = 1'b0;
        repeat (3) apply_stimulus();
        set_read(0, 10'h005); apply_stimulus();
        idle_all(); repeat (3) apply_stimulus();

        for (int n = 0; n < 60; n++) begin
            for (int p = 0; p < 2; p++) begin
                case ($urandom_range(0, 2))
                    0: idle_port(p);
                    1: set_read(p, 10'(10'h040 + $urandom_range(0, 7)));
                    default: set_write(p, 10'(10'h040 + $urandom_range(0, 7)), $urandom, 4'($urandom));
                endcase
            end
            clken = ($urandom_range(0, 4) != 0);
            apply_stimulus();
        end
        clken = 1'b1;
        idle_all(); repeat (4) apply_stimulus();

        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("drained_%0d", i), 32'(exp_q[i].size()), 32'h0);
        end
`ifdef SYSTEMA_RAM_DP_COLLISION_EN
        check_collision("coll_end");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/systema_ram_dp.md
Name: systema_ram_dp

Overview:
- Parametrised dual-port Avalon-MM on-chip RAM. Successor to the single-port system RAM.
- Two independent slave ports: s1 (CPU data master) and s2 (DMA / second master). Both share one word array.
- Configurable data width, depth and read latency. Adds a readdatavalid pipeline, defined cross-port collision rules, and a clock-enable freeze.
- Sits on the systema interconnect as the main program/data memory.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, word address width; depth = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values 1 or 2.
- INIT_FILE, "systema_RAM.hex", memory initialisation file (simulation/synthesis init only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- clken  in  1  global clock enable; low freezes both ports
- reset_req  in  1  reset-request; high freezes both ports, same as clken=0
- address  in  ADDR_WIDTH  s1 word address
- byteenable  in  DATA_WIDTH/8  s1 byte lanes
- chipselect  in  1  s1 select
- write  in  1  s1 write strobe
- read  in  1  s1 read strobe
- writedata  in  DATA_WIDTH  s1 write data
- readdata  out  DATA_WIDTH  s1 read data
- readdatavalid  out  1  s1 read data valid
- address2, byteenable2, chipselect2, write2, read2, writedata2  in  (same widths)  s2 equivalents
- readdata2  out  DATA_WIDTH  s2 read data
- readdatavalid2  out  1  s2 read data valid

Behaviour:
- Clock and reset: one clock. reset is asynchronous, active-high.
- On reset:
  - readdata, readdata2 = 0.
  - readdatavalid, readdatavalid2 = 0.
  - All pipeline valid bits cleared.
  - Array contents are NOT cleared.
- Reset during in-flight reads: the reads are dropped; no readdatavalid is issued for them after reset deasserts.
- Enable: en = clken & ~reset_req. When en=0:
  - No writes commit; no reads are accepted.
  - Pipeline registers and outputs hold their values, so readdatavalid stays at its current level.
- Per-port accept:
  - Write accepted when chipselect & write & en.
  - Read accepted when chipselect & read & ~write & en.
  - If write and read are both high, the write wins and the read is ignored (no readdatavalid).
- Write: each byte lane i with byteenable[i]=1 updates mem[address][8i+7:8i]. Lanes with byteenable[i]=0 are untouched. A write with byteenable=0 is a no-op.
- Read latency:
  - READ_LATENCY=1: data registered at the accept edge; readdatavalid=1 in the following cycle, for one cycle.
  - READ_LATENCY=2: one extra output register stage.
  - Back-to-back reads are accepted every cycle (fully pipelined).
  - readdatavalid is a one-cycle pulse per accepted read, in order.
- Read-during-write, same port: not possible (write wins).
- Read-during-write, cross port (s1 writes X while s2 reads X in the same cycle): the reader gets the OLD data. Same rule in the reverse direction.
- Dual write, same address, same cycle:
  - s1 wins on lanes enabled on both ports.
  - Lanes enabled only on s2 take s2 data.
  - Lanes enabled only on s1 take s1 data.
- Address range: addresses wrap naturally modulo depth; there is no out-of-range case.
- No waitrequest: both ports accept every cycle that en=1.

Optional Feature:
- Macro: SYSTEMA_RAM_DP_COLLISION_EN
- With the macro defined, two extra outputs are added:
  - collision (out, 1): sticky; set on any same-cycle same-address access pair where at least one side is an accepted write. Cleared only by reset.
  - collision_count (out, 16): increments once per such cycle; saturates at 16'hFFFF; reset value 0.
- With the macro undefined, neither port exists and no logic is generated.

Test Plan:
- Write/read latency 1: s1 write 0xDEADBEEF to addr 0x005 with byteenable=4'hF; read addr 0x005 next cycle -> readdata=0xDEADBEEF with readdatavalid high exactly 1 cycle after accept; readdatavalid2 stays 0.
- Byte lanes: preload 0x11223344 at addr 0x010; s2 write 0xAABBCCDD with byteenable2=4'b0101 -> s1 read returns 0x11BB33DD.
- Cross-port old data: addr 0x020 holds 0x0; s1 writes 0x12345678 while s2 reads 0x020 in the same cycle -> readdata2=0x00000000; an s2 read one cycle later returns 0x12345678.
- Dual write collision: s1 writes 0xFFFF0000 with byteenable 4'b1100 and s2 writes 0x0000FFFF with byteenable 4'b1111 to addr 0x3FF in the same cycle -> stored value 0xFFFFFFFF (s1 supplies lanes 3:2, s2 supplies lanes 1:0). With SYSTEMA_RAM_DP_COLLISION_EN defined: collision=1, collision_count=1.
- Freeze and pipeline: READ_LATENCY=2, back-to-back reads of addrs 1, 2, 3 with clken dropped for 2 cycles after the 2nd accept -> three readdatavalid pulses in order, delayed by 2 cycles; no write commits while clken=0.
- Reset mid-read: accept a read, then assert reset in the next cycle -> readdata=0 and readdatavalid=0 immediately; no valid pulse after release; memory contents preserved on a subsequent read.
